// File: rtl/spi_pkg.sv
// Shared definitions for the SPI burst sequencer slice.
// Contents:
//   DATA_LENGTH_DEF - default SPI word width
//   spi_state_e     - burst FSM states (IDLE, SETUP, SHIFT, HOLD, GAP)
//   level_width()   - width of a FIFO occupancy counter able to hold 0..depth
package spi_pkg;

  localparam int DATA_LENGTH_DEF = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } spi_state_e;

  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/spi_tx_fifo.sv
// Synchronous TX FIFO feeding the burst sequencer.
// Ports:
//   sys_clk, rst_n  - clock, asynchronous active-low reset (pointers/level cleared)
//   push, push_data - write request; ignored while full
//   pop             - read request; ignored while empty; head advances on the edge
//   head            - word at the read pointer (valid when !empty)
//   level           - occupancy 0..DEPTH
//   full, empty     - status flags derived from the registered level
// DEPTH must be a power of two so the pointers wrap naturally.
module spi_tx_fifo
  import spi_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = level_width(DEPTH)
) (
  input  logic          sys_clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      // Simultaneous push and pop leaves the level unchanged.
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: contents are only observable through valid pointers.
  always_ff @(posedge sys_clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/spi_burst_sequencer.sv
// Burst sequencer in front of the SPI shift engine: buffers TX words and frames
// multi-word bursts with chip select so the engine shifts words back-to-back.
// Ports:
//   sys_clk, rst_n          - clock, asynchronous active-low reset
//   wr_valid/wr_data/wr_ready - TX word write port (push on wr_valid && wr_ready)
//   start, burst_len        - burst request; burst_len 0 means 256 words
//   busy, done              - burst in progress / 1-cycle pulse entering GAP
//   fifo_level              - TX FIFO occupancy
//   cs_n, eng_enable, eng_data_in - SPI engine side
//   underrun                - sticky abort flag (only with SPI_SEQ_UNDERRUN_EN)
//   state_dbg               - current FSM state
// Handshake: a word transfers on every sys_clk edge where wr_valid and wr_ready
// are both high; wr_ready depends only on registered state, wr_data must be
// stable while wr_valid is high.
// Build option: SPI_SEQ_UNDERRUN_EN - when defined an empty FIFO at a word
// boundary aborts the burst and sets underrun; otherwise shifting stalls
// (enable low, cs_n held low) until a word arrives.
module spi_burst_sequencer
  import spi_pkg::*;
#(
  parameter int DATA_LENGTH = DATA_LENGTH_DEF,
  parameter int FIFO_DEPTH  = 8,
  parameter int CS_SETUP    = 2,
  parameter int CS_HOLD     = 2,
  parameter int GAP_MIN     = 1,
  localparam int LW         = level_width(FIFO_DEPTH)
) (
  input  logic                   sys_clk,
  input  logic                   rst_n,
  input  logic                   wr_valid,
  input  logic [DATA_LENGTH-1:0] wr_data,
  output logic                   wr_ready,
  input  logic                   start,
  input  logic [7:0]             burst_len,
  output logic                   busy,
  output logic                   done,
  output logic [LW-1:0]          fifo_level,
  output logic                   cs_n,
  output logic                   eng_enable,
  output logic [DATA_LENGTH-1:0] eng_data_in,
  output logic                   underrun,
  output spi_state_e             state_dbg
);

  localparam int BW = $clog2(DATA_LENGTH);

  spi_state_e             state;
  logic [7:0]             phase_cnt;
  logic [BW-1:0]          bit_cnt;
  logic [8:0]             words_left;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [DATA_LENGTH-1:0] fifo_head;
  logic                   pop;
  logic                   last_bit;

  assign wr_ready  = !fifo_full;
  assign busy      = (state != IDLE);
  assign state_dbg = state;
  assign last_bit  = (bit_cnt == BW'(DATA_LENGTH - 1));

  spi_tx_fifo #(
    .W     (DATA_LENGTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .push      (wr_valid),
    .push_data (wr_data),
    .pop       (pop),
    .head      (fifo_head),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Pop exactly when the FSM below loads eng_data_in from the FIFO head.
  always_comb begin
    pop = 1'b0;
    case (state)
      SETUP:   pop = (phase_cnt == 8'(CS_SETUP - 1));
      // Enable low inside SHIFT means a stall waiting for the next word.
      SHIFT:   pop = eng_enable ? (last_bit && (words_left > 9'd1) && !fifo_empty)
                                : !fifo_empty;
      default: pop = 1'b0;
    endcase
  end

`ifdef SPI_SEQ_UNDERRUN_EN
  logic underrun_q;
  assign underrun = underrun_q;
`else
  assign underrun = 1'b0;
`endif

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      phase_cnt   <= '0;
      bit_cnt     <= '0;
      words_left  <= '0;
      cs_n        <= 1'b1;
      eng_enable  <= 1'b0;
      eng_data_in <= '0;
      done        <= 1'b0;
`ifdef SPI_SEQ_UNDERRUN_EN
      underrun_q  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !fifo_empty) begin
            words_left <= (burst_len == 8'd0) ? 9'd256 : {1'b0, burst_len};
            phase_cnt  <= '0;
            cs_n       <= 1'b0;
            state      <= SETUP;
`ifdef SPI_SEQ_UNDERRUN_EN
            underrun_q <= 1'b0;
`endif
          end
        end
        SETUP: begin
          if (phase_cnt == 8'(CS_SETUP - 1)) begin
            eng_data_in <= fifo_head;
            eng_enable  <= 1'b1;
            bit_cnt     <= '0;
            state       <= SHIFT;
          end else begin
            phase_cnt <= phase_cnt + 8'd1;
          end
        end
        SHIFT: begin
          if (eng_enable) begin
            if (last_bit) begin
              bit_cnt <= '0;
              // words_left counts the word currently shifting.
              if (words_left == 9'd1) begin
                eng_enable <= 1'b0;
                phase_cnt  <= '0;
                state      <= HOLD;
              end else if (!fifo_empty) begin
                eng_data_in <= fifo_head;
                words_left  <= words_left - 9'd1;
              end else begin
`ifdef SPI_SEQ_UNDERRUN_EN
                underrun_q <= 1'b1;
                eng_enable <= 1'b0;
                phase_cnt  <= '0;
                state      <= HOLD;
`else
                eng_enable <= 1'b0;
`endif
              end
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end else if (!fifo_empty) begin
            eng_data_in <= fifo_head;
            words_left  <= words_left - 9'd1;
            eng_enable  <= 1'b1;
          end
        end
        HOLD: begin
          if (phase_cnt == 8'(CS_HOLD - 1)) begin
            cs_n      <= 1'b1;
            done      <= 1'b1;
            phase_cnt <= '0;
            state     <= GAP;
          end else begin
            phase_cnt <= phase_cnt + 8'd1;
          end
        end
        GAP: begin
          if (phase_cnt == 8'(GAP_MIN - 1)) state <= IDLE;
          else phase_cnt <= phase_cnt + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_burst_sequencer.sv
// Testbench for spi_burst_sequencer (default parameters: 8-bit words, 8-deep
// FIFO, CS_SETUP=2, CS_HOLD=2, GAP_MIN=1). Expected words come from a queue of
// accepted pushes; a negedge monitor summarises each burst as counts and the
// list of words seen on the engine port.
module tb_spi_burst_sequencer;
  import spi_pkg::*;

  localparam int DL = 8;

  // ---------------- clock / reset ----------------
  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic          wr_valid = 1'b0;
  logic [DL-1:0] wr_data  = '0;
  logic          wr_ready;
  logic          start = 1'b0;
  logic [7:0]    burst_len = 8'd0;
  logic          busy, done, cs_n, eng_enable, underrun;
  logic [3:0]    fifo_level;
  logic [DL-1:0] eng_data_in;
  spi_state_e    state_dbg;

  spi_burst_sequencer dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .start(start), .burst_len(burst_len), .busy(busy),
    .done(done), .fifo_level(fifo_level), .cs_n(cs_n), .eng_enable(eng_enable),
    .eng_data_in(eng_data_in), .underrun(underrun), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [DL-1:0] exp_q[$];
  logic [DL-1:0] seen_q[$];
  int tests_run = 0;
  int fail_cnt  = 0;
  int en_total, en_runs, setup_cnt, hold_cnt, gap_cnt, done_cnt, glitch_cnt;
  logic prev_en = 1'b0;
  logic [DL-1:0] cur_word;

  // Burst monitor: runs on the falling edge, away from the active edge.
  always @(negedge sys_clk) begin
    if (rst_n) begin
      if (eng_enable) begin
        if (!prev_en) en_runs++;
        if (en_total % DL == 0) begin
          seen_q.push_back(eng_data_in);
          cur_word = eng_data_in;
        end else if (eng_data_in !== cur_word) glitch_cnt++;
        en_total++;
      end else if (!cs_n) begin
        if (en_total == 0) setup_cnt++; else hold_cnt++;
      end else if (busy) gap_cnt++;
      if (done) done_cnt++;
      prev_en = eng_enable;
    end else prev_en = 1'b0;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge sys_clk); #1;
  endtask

  task automatic clear_mon();
    en_total = 0; en_runs = 0; setup_cnt = 0; hold_cnt = 0;
    gap_cnt = 0; done_cnt = 0; glitch_cnt = 0; seen_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; wr_valid = 1'b0; start = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    exp_q.delete();
    clear_mon();
  endtask

  task automatic push_word(input logic [DL-1:0] d, output bit acc);
    wr_valid = 1'b1; wr_data = d;
    acc = wr_ready;
    step();
    wr_valid = 1'b0;
    if (acc) exp_q.push_back(d);
  endtask

  task automatic start_burst(input int len);
    start = 1'b1; burst_len = 8'(len);
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int g = 0;
    while (busy && g < budget) begin step(); g++; end
    tests_run++;
    if (busy) begin fail_cnt++; $display("FAIL wait_idle: busy=%0b after %0d cycles, required 0", busy, g); end
  endtask

  // Start a burst on pre-loaded words, optionally feeding more words while it runs,
  // then compare the engine-side words against the head of the expected queue.
  task automatic run_burst(input int len_cfg, input int feed, input int coin_pct);
    int elen = (len_cfg == 0) ? 256 : len_cfg;
    int g = 0;
    bit acc;
    clear_mon();
    start_burst(len_cfg);
    while (busy && g < 5000) begin
      if (feed > 0 && $urandom_range(0, 99) < coin_pct) begin
        wr_valid = 1'b1; wr_data = DL'($urandom);
      end else wr_valid = 1'b0;
      acc = wr_valid && wr_ready;
      step();
      if (acc) begin exp_q.push_back(wr_data); feed--; end
      g++;
    end
    wr_valid = 1'b0;
    tests_run++;
    if (busy) begin fail_cnt++; $display("FAIL burst_timeout: still busy after %0d cycles", g); end
    tests_run++;
    if (seen_q.size() != elen) begin fail_cnt++; $display("FAIL burst_words: got %0d words, required %0d", seen_q.size(), elen); end
    for (int i = 0; i < elen && i < seen_q.size(); i++) begin
      logic [DL-1:0] e = exp_q.pop_front();
      tests_run++;
      if (seen_q[i] !== e) begin fail_cnt++; $display("FAIL burst_data[%0d]: got %h, required %h", i, seen_q[i], e); end
    end
    tests_run++;
    if (en_total != DL * elen) begin fail_cnt++; $display("FAIL burst_enable_cycles: got %0d, required %0d", en_total, DL * elen); end
    tests_run++;
    if (en_runs != 1 || glitch_cnt != 0) begin fail_cnt++; $display("FAIL burst_contiguous: runs=%0d glitches=%0d, required 1/0", en_runs, glitch_cnt); end
    tests_run++;
    if (done_cnt != 1) begin fail_cnt++; $display("FAIL burst_done: got %0d pulses, required 1", done_cnt); end
    tests_run++;
    if (fifo_level !== 4'(exp_q.size())) begin fail_cnt++; $display("FAIL burst_level: got %0d, required %0d", fifo_level, exp_q.size()); end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    tests_run++;
    if ({cs_n, eng_enable, busy, done, wr_ready, underrun} !== 6'b100010 || eng_data_in !== '0 || fifo_level !== '0) begin
      fail_cnt++;
      $display("FAIL reset_state: cs_n=%b en=%b busy=%b done=%b wr_ready=%b underrun=%b data=%h level=%0d", cs_n, eng_enable, busy, done, wr_ready, underrun, eng_data_in, fifo_level);
    end
  endtask

  task automatic test_basic();
    bit acc;
    do_reset();
    push_word(8'hA5, acc);
    push_word(8'h3C, acc);
    clear_mon();
    start_burst(2);
    wait_idle(100);
    tests_run++;
    if (setup_cnt != 2) begin fail_cnt++; $display("FAIL basic_setup: got %0d cycles, required 2", setup_cnt); end
    tests_run++;
    if (en_total != 16 || en_runs != 1) begin fail_cnt++; $display("FAIL basic_enable: got %0d cycles in %0d runs, required 16 in 1", en_total, en_runs); end
    tests_run++;
    if (seen_q.size() != 2 || seen_q[0] !== 8'hA5 || seen_q[1] !== 8'h3C) begin fail_cnt++; $display("FAIL basic_data: got %p, required A5,3C", seen_q); end
    tests_run++;
    if (hold_cnt != 2 || gap_cnt != 1) begin fail_cnt++; $display("FAIL basic_hold_gap: got hold=%0d gap=%0d, required 2/1", hold_cnt, gap_cnt); end
    tests_run++;
    if (done_cnt != 1 || glitch_cnt != 0) begin fail_cnt++; $display("FAIL basic_done: got done=%0d glitches=%0d, required 1/0", done_cnt, glitch_cnt); end
    exp_q.delete();
  endtask

  task automatic test_full();
    bit acc;
    int g;
    logic [DL-1:0] extra;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      push_word(DL'($urandom), acc);
      tests_run++;
      if (!acc) begin fail_cnt++; $display("FAIL full_fill[%0d]: wr_ready=0, required 1", i); end
    end
    tests_run++;
    if (fifo_level !== 4'd8 || wr_ready !== 1'b0) begin fail_cnt++; $display("FAIL full_level: got level=%0d wr_ready=%b, required 8/0", fifo_level, wr_ready); end
    push_word(8'hEE, acc);
    tests_run++;
    if (acc || fifo_level !== 4'd8) begin fail_cnt++; $display("FAIL full_ninth: got accepted=%b level=%0d, required 0/8", acc, fifo_level); end
    // Hold a pending write while a 1-word burst pops; the freed slot fills next cycle.
    extra = DL'($urandom);
    clear_mon();
    wr_valid = 1'b1; wr_data = extra;
    start_burst(1);
    g = 0;
    acc = 1'b0;
    while (!acc && g < 20) begin
      acc = wr_ready;
      step();
      g++;
    end
    wr_valid = 1'b0;
    if (acc) exp_q.push_back(extra);
    tests_run++;
    if (!acc || fifo_level !== 4'd8) begin fail_cnt++; $display("FAIL full_refill: got accepted=%b level=%0d, required 1/8", acc, fifo_level); end
    wait_idle(100);
    tests_run++;
    if (seen_q.size() != 1 || seen_q[0] !== exp_q[0]) begin fail_cnt++; $display("FAIL full_first_word: got %p, required %h", seen_q, exp_q[0]); end
    void'(exp_q.pop_front());
    // Drain across the pointer wrap.
    run_burst(8, 0, 0);
  endtask

  task automatic test_random();
    bit acc;
    do_reset();
    for (int it = 0; it < 6; it++) begin
      int n_pre = (exp_q.size() < 8) ? $urandom_range(1, 8 - exp_q.size()) : 0;
      for (int k = 0; k < n_pre; k++) push_word(DL'($urandom), acc);
      run_burst($urandom_range(1, exp_q.size()), $urandom_range(0, 4), 50);
    end
  endtask

  task automatic test_len256();
    bit acc;
    do_reset();
    for (int k = 0; k < 8; k++) push_word(DL'($urandom), acc);
    run_burst(0, 300, 100);
  endtask

  task automatic test_underrun();
    bit acc;
    do_reset();
    push_word(8'h5A, acc);
    clear_mon();
    start_burst(3);
    for (int k = 0; k < 25; k++) step();
`ifdef SPI_SEQ_UNDERRUN_EN
    tests_run++;
    if (underrun !== 1'b1 || busy !== 1'b0 || en_total != 8 || done_cnt != 1) begin fail_cnt++; $display("FAIL underrun_abort: got underrun=%b busy=%b en=%0d done=%0d, required 1/0/8/1", underrun, busy, en_total, done_cnt); end
    exp_q.delete();
    push_word(8'h11, acc);
    start_burst(1);
    tests_run++;
    if (underrun !== 1'b0) begin fail_cnt++; $display("FAIL underrun_clear: got %b, required 0", underrun); end
    wait_idle(100);
    exp_q.delete();
`else
    tests_run++;
    if (busy !== 1'b1 || cs_n !== 1'b0 || eng_enable !== 1'b0 || en_total != 8 || done_cnt != 0 || underrun !== 1'b0) begin
      fail_cnt++;
      $display("FAIL stall_hold: got busy=%b cs_n=%b en=%b en_cycles=%0d done=%0d underrun=%b, required 1/0/0/8/0/0", busy, cs_n, eng_enable, en_total, done_cnt, underrun);
    end
    push_word(8'hC3, acc);
    push_word(8'h7E, acc);
    wait_idle(100);
    tests_run++;
    if (en_total != 24 || en_runs != 2 || done_cnt != 1 || glitch_cnt != 0) begin fail_cnt++; $display("FAIL stall_resume: got en=%0d runs=%0d done=%0d glitches=%0d, required 24/2/1/0", en_total, en_runs, done_cnt, glitch_cnt); end
    tests_run++;
    if (seen_q.size() != 3 || seen_q[0] !== 8'h5A || seen_q[1] !== 8'hC3 || seen_q[2] !== 8'h7E) begin fail_cnt++; $display("FAIL stall_data: got %p, required 5A,C3,7E", seen_q); end
    exp_q.delete();
`endif
  endtask

  task automatic test_ignored_start();
    bit acc;
    do_reset();
    start_burst(1);
    step(); step();
    tests_run++;
    if (busy !== 1'b0 || cs_n !== 1'b1) begin fail_cnt++; $display("FAIL start_empty: got busy=%b cs_n=%b, required 0/1", busy, cs_n); end
    push_word(8'h21, acc);
    push_word(8'h42, acc);
    clear_mon();
    start_burst(1);
    step(); step();
    start_burst(5);
    tests_run++;
    if (busy !== 1'b1 || cs_n !== 1'b0) begin fail_cnt++; $display("FAIL start_busy: got busy=%b cs_n=%b, required 1/0", busy, cs_n); end
    wait_idle(100);
    tests_run++;
    if (en_total != 8 || done_cnt != 1 || fifo_level !== 4'd1 || seen_q.size() != 1 || seen_q[0] !== 8'h21) begin
      fail_cnt++;
      $display("FAIL start_busy_result: got en=%0d done=%0d level=%0d words=%0d, required 8/1/1/1 with 21", en_total, done_cnt, fifo_level, seen_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    bit acc;
    int g = 0;
    do_reset();
    for (int k = 0; k < 3; k++) push_word(DL'($urandom), acc);
    clear_mon();
    start_burst(3);
    while (en_total < 12 && g < 100) begin step(); g++; end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (cs_n !== 1'b1 || eng_enable !== 1'b0 || fifo_level !== '0 || busy !== 1'b0 || wr_ready !== 1'b1) begin
      fail_cnt++;
      $display("FAIL reset_mid: got cs_n=%b en=%b level=%0d busy=%b wr_ready=%b, required 1/0/0/0/1", cs_n, eng_enable, fifo_level, busy, wr_ready);
    end
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) step();
    tests_run++;
    if (done_cnt != 0 || cs_n !== 1'b1 || fifo_level !== '0) begin fail_cnt++; $display("FAIL reset_mid_after: got done=%0d cs_n=%b level=%0d, required 0/1/0", done_cnt, cs_n, fifo_level); end
    exp_q.delete();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_full();
    test_random();
    test_len256();
    test_underrun();
    test_ignored_start();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
